fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_pc_reg.sv | 73 +++++++
 rtl/fetch_stage.sv | 60 ++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage: state encoding, PC step
// sizes, and the instruction-memory range helper.
package fetch_stage_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] R15_OFFSET       = 32'd8;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // True when a word index lies inside an instruction memory of 'words' entries.
  function automatic logic word_in_range(input logic [29:0] word_idx,
                                         input int unsigned words);
    return 32'(word_idx) < words;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// PC register with next-PC selection, RUN/HALT control and fetch-fault detection.
// Tells the IF/ID register when to capture a new instruction and when to flush.
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        redirect,
  input  logic [31:0] pc_target,
  input  logic        valid_id,
  input  logic        id_ready,
  output logic [31:0] pc,
  output logic        fault,
  output logic        capture,
  output logic        flush
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic         advance;

  assign advance = (!valid_id || id_ready) && (state_q == RUN);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    capture = 1'b0;
    flush   = 1'b0;
    if (state_q == RUN) begin
      if (redirect) begin
        // Redirect wins over stall, advance and an out-of-range current PC.
        pc_d  = pc_target;
        flush = 1'b1;
        if (pc_target[1:0] != 2'b00) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end else if (!word_in_range(pc_q[31:2], MEM_WORDS)) begin
        fault_d = 1'b1;
        state_d = HALT;
        flush   = 1'b1;
      end else if (advance) begin
        capture = 1'b1;
        pc_d    = pc_q + PC_STEP;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign pc    = pc_q;
  assign fault = fault_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the fetch address to an external instruction
// memory and holds the fetched word in the IF/ID register for decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        Redirect,
  input  logic [31:0] PCTarget,
  input  logic        ID_Ready,
  output logic [31:0] PC_IMEM,
  input  logic [31:0] Instr_IMEM,
  output logic [31:0] Instr_ID,
  output logic [31:0] PC_ID,
  output logic [31:0] PCPlus8_ID,
  output logic        Valid_ID,
  output logic        Fault
);

  logic capture;
  logic flush;

  fetch_pc_reg #(
    .RESET_PC  (RESET_PC),
    .MEM_WORDS (MEM_WORDS)
  ) u_pc_reg (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .redirect  (Redirect),
    .pc_target (PCTarget),
    .valid_id  (Valid_ID),
    .id_ready  (ID_Ready),
    .pc        (PC_IMEM),
    .fault     (Fault),
    .capture   (capture),
    .flush     (flush)
  );

  // NOTE: the IF/ID payload is reset along with Valid_ID so decode never sees
  // stale words after reset; it is a handful of flops, not a memory array.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      Instr_ID   <= '0;
      PC_ID      <= '0;
      PCPlus8_ID <= '0;
      Valid_ID   <= 1'b0;
    end else if (capture) begin
      Instr_ID   <= Instr_IMEM;
      PC_ID      <= PC_IMEM;
      PCPlus8_ID <= PC_IMEM + R15_OFFSET;
      Valid_ID   <= 1'b1;
    end else if (flush) begin
      Valid_ID   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed vector table covering fetch,
// stall, redirect, fault and reset, plus a straight-line run to the memory end.
module tb_fetch_stage;

  logic        CLK;
  logic        RESETn;
  logic        Redirect;
  logic [31:0] PCTarget;
  logic        ID_Ready;
  logic [31:0] PC_IMEM;
  logic [31:0] Instr_IMEM;
  logic [31:0] Instr_ID;
  logic [31:0] PC_ID;
  logic [31:0] PCPlus8_ID;
  logic        Valid_ID;
  logic        Fault;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .Redirect   (Redirect),
    .PCTarget   (PCTarget),
    .ID_Ready   (ID_Ready),
    .PC_IMEM    (PC_IMEM),
    .Instr_IMEM (Instr_IMEM),
    .Instr_ID   (Instr_ID),
    .PC_ID      (PC_ID),
    .PCPlus8_ID (PCPlus8_ID),
    .Valid_ID   (Valid_ID),
    .Fault      (Fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory contents: two ARM words, then a recognisable pattern.
  function automatic logic [31:0] word_at(input int unsigned idx);
    if (idx == 0) return 32'hE590_9C04;
    if (idx == 1) return 32'hE580_9C00;
    return 32'hA500_0000 + 32'(idx);
  endfunction

  always_comb begin
    if (PC_IMEM[31:9] == '0) Instr_IMEM = word_at(int'(PC_IMEM[8:2]));
    else                     Instr_IMEM = 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rstn;
    logic        redir;
    logic [31:0] target;
    logic        rdy;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc_id;
    logic [31:0] exp_p8;
    logic        exp_fault;
  } vec_t;

  function automatic vec_t v(input logic rstn, input logic redir,
                             input logic [31:0] target, input logic rdy,
                             input logic [31:0] pc, input logic valid,
                             input logic [31:0] instr, input logic [31:0] pc_id,
                             input logic [31:0] p8, input logic fault);
    vec_t r;
    r.rstn = rstn; r.redir = redir; r.target = target; r.rdy = rdy;
    r.exp_pc = pc; r.exp_valid = valid; r.exp_instr = instr;
    r.exp_pc_id = pc_id; r.exp_p8 = p8; r.exp_fault = fault;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, " PC_IMEM"},    PC_IMEM,          e.exp_pc);
    check({tag, " Valid_ID"},   32'(Valid_ID),    32'(e.exp_valid));
    check({tag, " Instr_ID"},   Instr_ID,         e.exp_instr);
    check({tag, " PC_ID"},      PC_ID,            e.exp_pc_id);
    check({tag, " PCPlus8_ID"}, PCPlus8_ID,       e.exp_p8);
    check({tag, " Fault"},      32'(Fault),       32'(e.exp_fault));
  endtask

  // Hard time limit so a broken design can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] W0 = 32'hE590_9C04;
  localparam logic [31:0] W1 = 32'hE580_9C00;

  initial begin
    vec_t tbl[$];

    // Straight fetch, 3-cycle stall, redirect under stall, end-of-memory fault,
    // reset from HALT, reset mid-stall, misaligned redirect, redirect that
    // rescues an out-of-range PC.
    tbl.push_back(v(1,0,32'h0,  1, 32'h4,  1, W0, 32'h0, 32'h8, 0));
    tbl.push_back(v(1,0,32'h0,  1, 32'h8,  1, W1, 32'h4, 32'hC, 0));
    tbl.push_back(v(1,0,32'h0,  0, 32'h8,  1, W1, 32'h4, 32'hC, 0));
    tbl.push_back(v(1,0,32'h0,  0, 32'h8,  1, W1, 32'h4, 32'hC, 0));
    tbl.push_back(v(1,0,32'h0,  0, 32'h8,  1, W1, 32'h4, 32'hC, 0));
    tbl.push_back(v(1,0,32'h0,  1, 32'hC,  1, 32'hA500_0002, 32'h8, 32'h10, 0));
    tbl.push_back(v(1,0,32'h0,  1, 32'h10, 1, 32'hA500_0003, 32'hC, 32'h14, 0));
    tbl.push_back(v(1,1,32'h0,  0, 32'h0,  0, 32'hA500_0003, 32'hC, 32'h14, 0));
    tbl.push_back(v(1,0,32'h0,  0, 32'h4,  1, W0, 32'h0, 32'h8, 0));
    tbl.push_back(v(1,1,32'h20, 1, 32'h20, 0, W0, 32'h0, 32'h8, 0));
    tbl.push_back(v(1,0,32'h0,  1, 32'h24, 1, 32'hA500_0008, 32'h20, 32'h28, 0));
    tbl.push_back(v(1,1,32'h1F8,1, 32'h1F8,0, 32'hA500_0008, 32'h20, 32'h28, 0));
    tbl.push_back(v(1,0,32'h0,  1, 32'h1FC,1, 32'hA500_007E, 32'h1F8, 32'h200, 0));
    tbl.push_back(v(1,0,32'h0,  1, 32'h200,1, 32'hA500_007F, 32'h1FC, 32'h204, 0));
    tbl.push_back(v(1,0,32'h0,  1, 32'h200,0, 32'hA500_007F, 32'h1FC, 32'h204, 1));
    tbl.push_back(v(1,1,32'h0,  1, 32'h200,0, 32'hA500_007F, 32'h1FC, 32'h204, 1));
    tbl.push_back(v(0,0,32'h0,  1, 32'h0,  0, 32'h0, 32'h0, 32'h0, 0));
    tbl.push_back(v(1,0,32'h0,  1, 32'h4,  1, W0, 32'h0, 32'h8, 0));
    tbl.push_back(v(1,0,32'h0,  1, 32'h8,  1, W1, 32'h4, 32'hC, 0));
    tbl.push_back(v(1,0,32'h0,  0, 32'h8,  1, W1, 32'h4, 32'hC, 0));
    tbl.push_back(v(0,1,32'h40, 0, 32'h0,  0, 32'h0, 32'h0, 32'h0, 0));
    tbl.push_back(v(1,1,32'h6,  1, 32'h6,  0, 32'h0, 32'h0, 32'h0, 1));
    tbl.push_back(v(1,1,32'h0,  1, 32'h6,  0, 32'h0, 32'h0, 32'h0, 1));
    tbl.push_back(v(1,0,32'h0,  1, 32'h6,  0, 32'h0, 32'h0, 32'h0, 1));
    tbl.push_back(v(0,0,32'h0,  1, 32'h0,  0, 32'h0, 32'h0, 32'h0, 0));
    tbl.push_back(v(1,1,32'h200,1, 32'h200,0, 32'h0, 32'h0, 32'h0, 0));
    tbl.push_back(v(1,1,32'h10, 1, 32'h10, 0, 32'h0, 32'h0, 32'h0, 0));
    tbl.push_back(v(1,0,32'h0,  1, 32'h14, 1, 32'hA500_0004, 32'h10, 32'h18, 0));

    RESETn   = 1'b0;
    Redirect = 1'b0;
    PCTarget = 32'h0;
    ID_Ready = 1'b1;
    step();
    step();
    check_all("reset", v(0,0,32'h0,1, 32'h0,0, 32'h0,32'h0,32'h0,0));

    foreach (tbl[i]) begin
      RESETn   = tbl[i].rstn;
      Redirect = tbl[i].redir;
      PCTarget = tbl[i].target;
      ID_Ready = tbl[i].rdy;
      step();
      check_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Straight-line run from reset to the end of the 128-word memory.
    RESETn   = 1'b0;
    Redirect = 1'b0;
    PCTarget = 32'h0;
    ID_Ready = 1'b1;
    step();
    RESETn = 1'b1;
    for (int k = 0; k < 128; k++) begin
      step();
      check($sformatf("run%0d PC_ID", k),    PC_ID,         32'(k) * 32'd4);
      check($sformatf("run%0d Instr_ID", k), Instr_ID,      word_at(k));
      check($sformatf("run%0d Valid_ID", k), 32'(Valid_ID), 32'd1);
    end
    step();
    check("run_end Fault",    32'(Fault),    32'd1);
    check("run_end Valid_ID", 32'(Valid_ID), 32'd0);
    check("run_end PC_ID",    PC_ID,         32'h1FC);
    check("run_end PC_IMEM",  PC_IMEM,       32'h200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
